mine_dp_gen: RTL and testbench
==============================

Name: mine_dp_gen

Overview:
- Parametrised second-generation Minesweeper datapath for a ROWS x COLS board.
- Places MINE_COUNT mines with an on-chip LFSR, or loads a fixed map for test.
- Accepts reveal commands over a valid/ready handshake and returns hit/error status plus an 8-neighbour adjacency count.
- Tracks the cleared cells, game over, win, and a saturating win score. Sits between the game-control FSM and the display/score logic, on a single clock.

Parameters:
- ROWS, 5, board rows.
- COLS, 5, board columns.
- MINE_COUNT, 3, mines placed; must satisfy 1 <= MINE_COUNT < ROWS*COLS (elaboration error otherwise).
- SCORE_W, 32, width of global_score.
- Derived (localparam, not overridable): CELLS = ROWS*COLS; IDX_W = clog2(CELLS).

Ports:
- clka  in  1  clock; all logic on rising edge.
- restart_n  in  1  asynchronous active-low reset.
- start  in  1  begin a new game (single-cycle pulse).
- load_map  in  1  sampled with start: 1 loads mine_map, 0 places mines with the LFSR.
- mine_map  in  CELLS  fixed mine layout, bit i = cell i (row-major, i = row*COLS + col).
- seed  in  16  LFSR seed, sampled with start.
- place_done  out  1  one-cycle pulse when placement completes.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_op  in  1  0 = reveal, 1 = flag toggle (see Optional Feature).
- cmd_idx  in  IDX_W  target cell.
- resp_valid  out  1  one-cycle response pulse.
- resp_hit  out  1  the revealed cell was a mine.
- resp_err  out  1  index out of range, or reveal of a flagged cell.
- resp_adj  out  4  mines among the 8 neighbours (0..8).
- mines  out  CELLS  mine map.
- cleared  out  CELLS  revealed cells.
- flags  out  CELLS  flagged cells.
- gameover  out  1  game finished (lost or won).
- win  out  1  game won.
- global_score  out  SCORE_W  total wins.

Behaviour:
- Reset: every register and output is 0; FSM goes to IDLE asynchronously; the LFSR is loaded with 16'hACE1.
- FSM states: IDLE, PLACE, READY, DECODE, EVAL, OVER.
- start:
  - Acts in IDLE, READY or OVER; ignored in PLACE, DECODE and EVAL.
  - Clears mines, cleared, flags, gameover and win; global_score is kept.
  - load_map=1: mines <= mine_map, with bits at index >= CELLS forced to 0. place_done pulses the next cycle, then the FSM enters READY.
  - load_map=0: the LFSR is loaded with seed (16'hACE1 when seed==0), then the FSM enters PLACE.
- PLACE:
  - The LFSR advances once per cycle (Galois, taps 0xB400). Candidate = lfsr[IDX_W-1:0].
  - A candidate >= CELLS, or one that is already a mine, is skipped. Otherwise its mines bit is set.
  - Once MINE_COUNT bits are set: place_done pulses, then READY.
- cmd_ready is high only in READY. A command accepted in cycle T drives resp_valid in cycle T+2 (DECODE, then EVAL). Command fields are latched at acceptance.
- Reveal, evaluated in EVAL:
  - idx >= CELLS: resp_err=1, no state change.
  - Mine cell: resp_hit=1, gameover=1, cleared unchanged; then OVER.
  - Other cell: cleared |= onehot(idx). resp_adj is the neighbour count computed with board-edge clipping.
  - Re-revealing an already cleared cell is legal: no change, resp_adj is reported.
  - Win condition: cleared == ~mines over the CELLS bits. On win: win=1, gameover=1, global_score += 1 (saturating at all-ones); then OVER.
  - After a non-terminal response the FSM returns to READY.
- OVER: gameover, win, mines and cleared are held; only start or reset leaves this state.
- Response fields are valid only while resp_valid=1 and are held at 0 otherwise.
- restart_n asserted in any state, including mid-PLACE or mid-command, aborts immediately; no response is issued.

Optional Feature:
- Macro MINE_FLAG_EN.
- Defined: cmd_op=1 toggles flags[idx], responding with resp_valid and resp_adj=0. A flag toggle on a cleared cell does nothing. A reveal of a flagged cell returns resp_err=1 with no state change. Flags never affect win.
- Undefined: cmd_op is ignored (every command is a reveal); the flags output is tied to 0.

Decomposition:
- Package mine_pkg holds:
  - the FSM state enum;
  - opcode constants OP_REVEAL and OP_FLAG;
  - LFSR_TAPS = 16'hB400 and LFSR_DEFAULT = 16'hACE1;
  - function adj_count(map, idx), parametrised by ROWS and COLS.
- Sub-module mine_lfsr: 16-bit Galois LFSR with load and step inputs and zero-seed substitution.

Test Plan:
- With load_map=1 and mine_map=0x0000007: reveal idx 6 -> resp_adj=3, resp_hit=0; reveal idx 7 -> resp_adj=2; cleared=0x00000C0.
- Same map: reveal idx 1 -> resp_hit=1, gameover=1, win=0, cmd_ready=0 afterwards, global_score unchanged.
- mine_map=0x1000000: reveal idx 0..23 -> the final response sets win=1, gameover=1 and global_score 0->1; a following start keeps global_score=1 and clears cleared.
- Reveal idx 25 (5x5 board) -> resp_err=1, cleared and gameover unchanged, FSM back in READY.
- load_map=0, seed=0, run twice -> popcount(mines)=3 both times, identical maps, place_done pulses exactly once per game.
- restart_n pulsed low during PLACE and during DECODE -> all outputs 0 at once, no resp_valid; with MINE_FLAG_EN, flag idx 3 then reveal idx 3 -> resp_err=1.

Source files
------------

// File: rtl/mine_dp_gen_pkg.sv
// Shared types, constants and the neighbour-count helper for the minesweeper datapath.
package mine_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLACE,
    READY,
    DECODE,
    EVAL,
    OVER
  } state_t;

  localparam logic        OP_REVEAL    = 1'b0;
  localparam logic        OP_FLAG      = 1'b1;
  localparam logic [15:0] LFSR_TAPS    = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT = 16'hACE1;

  // Widest board the helper accepts; maps are zero-padded up to this size.
  localparam int MAX_CELLS = 256;

  function automatic logic [3:0] adj_count(input logic [MAX_CELLS-1:0] map,
                                           input int idx,
                                           input int rows,
                                           input int cols);
    int r;
    int c;
    int k;
    logic [3:0] n;
    n = 4'd0;
    r = idx / cols;
    c = idx % cols;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        k = (r + dr) * cols + (c + dc);
        if ((dr != 0 || dc != 0) && (r + dr) >= 0 && (r + dr) < rows &&
            (c + dc) >= 0 && (c + dc) < cols && map[k[7:0]])
          n = n + 4'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/mine_dp_gen_if.sv
// Command/response bundle between the game-control FSM (master) and the datapath (slave).
interface mine_cmd_if #(
  parameter int IDX_W = 5
);
  // A command transfers on a rising clock edge where cmd_valid && cmd_ready;
  // the master holds cmd_op/cmd_idx stable while cmd_valid is high and unaccepted.
  // The response is a single-cycle resp_valid pulse with no back-pressure.
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_op;
  logic [IDX_W-1:0] cmd_idx;
  logic             resp_valid;
  logic             resp_hit;
  logic             resp_err;
  logic [3:0]       resp_adj;

  modport master (
    output cmd_valid, cmd_op, cmd_idx,
    input  cmd_ready, resp_valid, resp_hit, resp_err, resp_adj
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_idx,
    output cmd_ready, resp_valid, resp_hit, resp_err, resp_adj
  );
endinterface

// File: rtl/mine_dp_gen_lfsr.sv
// 16-bit Galois LFSR used for mine placement; a zero seed is replaced by the default.
module mine_lfsr
  import mine_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] next_val;

  always_comb begin
    next_val = {1'b0, value[15:1]};
    if (value[0]) next_val = next_val ^ LFSR_TAPS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    value <= LFSR_DEFAULT;
    else if (load) value <= (seed == 16'h0000) ? LFSR_DEFAULT : seed;
    else if (step) value <= next_val;
  end

endmodule

// File: rtl/mine_dp_gen.sv
// Minesweeper datapath: mine placement, reveal/flag commands, win tracking and score.
// Optional flag support is compiled in with `define MINE_FLAG_EN.
module mine_dp_gen
  import mine_pkg::*;
#(
  parameter int  ROWS       = 5,
  parameter int  COLS       = 5,
  parameter int  MINE_COUNT = 3,
  parameter int  SCORE_W    = 32,
  localparam int CELLS      = ROWS * COLS,
  localparam int IDX_W      = $clog2(CELLS)
) (
  input  logic               clka,
  input  logic               restart_n,
  input  logic               start,
  input  logic               load_map,
  input  logic [CELLS-1:0]   mine_map,
  input  logic [15:0]        seed,
  output logic               place_done,
  mine_cmd_if.slave          cmd,
  output logic [CELLS-1:0]   mines,
  output logic [CELLS-1:0]   cleared,
  output logic [CELLS-1:0]   flags,
  output logic               gameover,
  output logic               win,
  output logic [SCORE_W-1:0] global_score,
  output state_t             state_dbg
);

  if (MINE_COUNT < 1 || MINE_COUNT >= CELLS) begin : g_bad_mine_count
    $error("mine_dp_gen: MINE_COUNT must satisfy 1 <= MINE_COUNT < ROWS*COLS");
  end
  if (CELLS > MAX_CELLS) begin : g_bad_board
    $error("mine_dp_gen: board larger than MAX_CELLS");
  end

  localparam logic [IDX_W:0]   CELLS_W  = (IDX_W + 1)'(CELLS);
  localparam logic [IDX_W-1:0] LAST_CNT = IDX_W'(MINE_COUNT - 1);
  localparam logic [CELLS-1:0] ONE      = {{(CELLS - 1){1'b0}}, 1'b1};

  state_t               state, state_nxt;
  logic [15:0]          lfsr_val;
  logic [IDX_W-1:0]     cand, lat_idx, place_cnt;
  logic [CELLS-1:0]     cand_oh, idx_oh, clr_nxt;
  logic [MAX_CELLS-1:0] mines_pad;
  logic                 start_go, accept, cand_ok, last_mine;
  logic                 idx_bad, is_mine, flagged, flag_op;
  logic                 dec_err, dec_hit, win_now, eval_over;
  logic [3:0]           dec_adj, adj_cnt;
  logic                 unused_lfsr;

  assign state_dbg   = state;
  assign start_go    = start && (state == IDLE || state == READY || state == OVER);
  assign accept      = cmd.cmd_valid && cmd.cmd_ready;
  assign unused_lfsr = ^lfsr_val[15:IDX_W];

  mine_lfsr u_lfsr (
    .clk   (clka),
    .rst_n (restart_n),
    .load  (start_go && !load_map),
    .step  (state == PLACE),
    .seed  (seed),
    .value (lfsr_val)
  );

  // Placement: out-of-board and duplicate candidates are simply skipped.
  assign cand      = lfsr_val[IDX_W-1:0];
  assign cand_oh   = ONE << cand;
  assign cand_ok   = (state == PLACE) && ({1'b0, cand} < CELLS_W) && !(|(mines & cand_oh));
  assign last_mine = (place_cnt == LAST_CNT);

  always_comb begin
    mines_pad            = '0;
    mines_pad[CELLS-1:0] = mines;
  end

  assign idx_oh  = ONE << lat_idx;
  assign idx_bad = ({1'b0, lat_idx} >= CELLS_W);
  assign is_mine = |(mines & idx_oh);
  assign adj_cnt = adj_count(mines_pad, int'(lat_idx), ROWS, COLS);
  assign clr_nxt = cleared | idx_oh;
  assign win_now = (state == EVAL) && !dec_err && !flag_op && !dec_hit && (clr_nxt == ~mines);
  assign eval_over = dec_hit || win_now;

  assign cmd.cmd_ready  = (state == READY) && !start;
  assign cmd.resp_valid = (state == EVAL);
  assign cmd.resp_hit   = (state == EVAL) && dec_hit;
  assign cmd.resp_err   = (state == EVAL) && dec_err;
  assign cmd.resp_adj   = (state == EVAL) ? dec_adj : 4'd0;

`ifdef MINE_FLAG_EN
  logic             lat_op;
  logic [CELLS-1:0] flags_q;

  assign flag_op = (lat_op == OP_FLAG);
  assign flagged = |(flags_q & idx_oh);
  assign flags   = flags_q;

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      lat_op  <= OP_REVEAL;
      flags_q <= '0;
    end else begin
      if (accept) lat_op <= cmd.cmd_op;
      if (start_go) flags_q <= '0;
      else if (state == EVAL && flag_op && !dec_err && !(|(cleared & idx_oh)))
        flags_q <= flags_q ^ idx_oh;
    end
  end
`else
  logic unused_op;
  assign unused_op = cmd.cmd_op;
  assign flag_op   = 1'b0;
  assign flagged   = 1'b0;
  assign flags     = '0;
`endif

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, OVER: if (start) state_nxt = load_map ? READY : PLACE;
      READY: begin
        if (start)       state_nxt = load_map ? READY : PLACE;
        else if (accept) state_nxt = DECODE;
      end
      PLACE:   if (cand_ok && last_mine) state_nxt = READY;
      DECODE:  state_nxt = EVAL;
      EVAL:    state_nxt = eval_over ? OVER : READY;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clka or negedge restart_n) begin
    if (!restart_n) begin
      mines        <= '0;
      cleared      <= '0;
      gameover     <= 1'b0;
      win          <= 1'b0;
      global_score <= '0;
      place_done   <= 1'b0;
      place_cnt    <= '0;
      lat_idx      <= '0;
      dec_err      <= 1'b0;
      dec_hit      <= 1'b0;
      dec_adj      <= 4'd0;
    end else begin
      place_done <= 1'b0;
      if (start_go) begin
        cleared   <= '0;
        gameover  <= 1'b0;
        win       <= 1'b0;
        place_cnt <= '0;
        if (load_map) begin
          mines      <= mine_map;
          place_done <= 1'b1;
        end else begin
          mines <= '0;
        end
      end else begin
        case (state)
          PLACE: if (cand_ok) begin
            mines     <= mines | cand_oh;
            place_cnt <= place_cnt + IDX_W'(1);
            if (last_mine) place_done <= 1'b1;
          end
          READY: if (accept) lat_idx <= cmd.cmd_idx;
          DECODE: begin
            dec_err <= idx_bad || (!flag_op && flagged);
            dec_hit <= !idx_bad && !flag_op && !flagged && is_mine;
            dec_adj <= (idx_bad || flag_op || flagged) ? 4'd0 : adj_cnt;
          end
          EVAL: if (!dec_err && !flag_op) begin
            if (dec_hit) begin
              gameover <= 1'b1;
            end else begin
              cleared <= clr_nxt;
              if (win_now) begin
                win      <= 1'b1;
                gameover <= 1'b1;
                if (global_score != '1) global_score <= global_score + SCORE_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mine_dp_gen.sv
// Directed bench for mine_dp_gen on the default 5x5 board with 3 mines.
module tb_mine_dp_gen;
  import mine_pkg::*;

  localparam int CELLS = 25;

  // ---------------- clock / reset ----------------
  logic clka = 1'b0;
  logic restart_n = 1'b0;
  always #5 clka = ~clka;

  logic             start = 1'b0;
  logic             load_map = 1'b0;
  logic [CELLS-1:0] mine_map = '0;
  logic [15:0]      seed = '0;
  logic             place_done;
  logic [CELLS-1:0] mines, cleared, flags;
  logic             gameover, win;
  logic [31:0]      global_score;
  state_t           state_dbg;

  mine_cmd_if #(.IDX_W(5)) cmd_bus ();

  mine_dp_gen dut (
    .clka         (clka),
    .restart_n    (restart_n),
    .start        (start),
    .load_map     (load_map),
    .mine_map     (mine_map),
    .seed         (seed),
    .place_done   (place_done),
    .cmd          (cmd_bus),
    .mines        (mines),
    .cleared      (cleared),
    .flags        (flags),
    .gameover     (gameover),
    .win          (win),
    .global_score (global_score),
    .state_dbg    (state_dbg)
  );

  int n_checks = 0;
  int n_errors = 0;
  int pd_cnt = 0;
  int resp_cnt = 0;
  logic [5:0] exp_q[$];

  always @(negedge clka) begin
    if (place_done) pd_cnt++;
    if (cmd_bus.resp_valid) resp_cnt++;
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic new_game(input string tag, input logic lm, input logic [CELLS-1:0] map,
                          input logic [15:0] sd);
    bit ok;
    @(negedge clka);
    start = 1'b1; load_map = lm; mine_map = map; seed = sd;
    @(negedge clka);
    start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (place_done) begin ok = 1'b1; break; end
      @(negedge clka);
    end
    check({tag, "_place_done"}, 32'(ok), 32'd1);
  endtask

  task automatic do_cmd(input string tag, input logic op, input logic [4:0] idx,
                        input logic eh, input logic ee, input logic [3:0] ea);
    logic [5:0] got, exp;
    bit acc, seen;
    exp_q.push_back({eh, ee, ea});
    cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_op = op; cmd_bus.cmd_idx = idx;
    acc = 1'b0;
    for (int i = 0; i < 20; i++) begin
      acc = cmd_bus.cmd_ready;
      @(negedge clka);
      if (acc) break;
    end
    cmd_bus.cmd_valid = 1'b0;
    seen = 1'b0; got = '0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_bus.resp_valid) begin
        seen = 1'b1;
        got = {cmd_bus.resp_hit, cmd_bus.resp_err, cmd_bus.resp_adj};
        break;
      end
      @(negedge clka);
    end
    @(negedge clka);
    check({tag, "_accept"}, 32'(acc), 32'd1);
    check({tag, "_resp_seen"}, 32'(seen), 32'd1);
    exp = exp_q.pop_front();
    check({tag, "_resp"}, 32'(got), 32'(exp));
  endtask

  // ---------------- stimulus ----------------
  logic [CELLS-1:0] map_a;
  logic [3:0] ea;
  int pd0, r0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_bus.cmd_valid = 1'b0; cmd_bus.cmd_op = 1'b0; cmd_bus.cmd_idx = '0;
    repeat (3) @(negedge clka);
    check("rst_mines", 32'(mines), 32'd0);
    check("rst_cleared", 32'(cleared), 32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_over_win", 32'({gameover, win, place_done}), 32'd0);
    check("rst_score", global_score, 32'd0);
    check("rst_ready", 32'({cmd_bus.cmd_ready, cmd_bus.resp_valid}), 32'd0);
    check("rst_state", 32'(state_dbg), 32'(IDLE));
    restart_n = 1'b1;

    // Adjacency on a fixed map with mines at 0,1,2
    new_game("map7", 1'b1, 25'h0000007, 16'h0);
    check("map7_mines", 32'(mines), 32'h7);
    do_cmd("rev6", 1'b0, 5'd6, 1'b0, 1'b0, 4'd3);
    do_cmd("rev7", 1'b0, 5'd7, 1'b0, 1'b0, 4'd2);
    check("cleared_c0", 32'(cleared), 32'hC0);
    do_cmd("rev25", 1'b0, 5'd25, 1'b0, 1'b1, 4'd0);
    check("err_cleared", 32'(cleared), 32'hC0);
    check("err_gameover", 32'(gameover), 32'd0);
    check("err_ready", 32'(state_dbg), 32'(READY));
    do_cmd("rerev7", 1'b0, 5'd7, 1'b0, 1'b0, 4'd2);
    check("rerev_cleared", 32'(cleared), 32'hC0);

    // Loss
    do_cmd("rev1", 1'b0, 5'd1, 1'b1, 1'b0, 4'd2);
    check("loss_gameover", 32'(gameover), 32'd1);
    check("loss_win", 32'(win), 32'd0);
    check("loss_cmd_ready", 32'(cmd_bus.cmd_ready), 32'd0);
    check("loss_score", global_score, 32'd0);
    check("loss_cleared", 32'(cleared), 32'hC0);
    check("idle_resp_zero", 32'({cmd_bus.resp_hit, cmd_bus.resp_err, cmd_bus.resp_adj}), 32'd0);

    // Win with a single mine at cell 24
    new_game("map24", 1'b1, 25'h1000000, 16'h0);
    check("map24_cleared", 32'(cleared), 32'd0);
    check("map24_gameover", 32'(gameover), 32'd0);
    for (int i = 0; i < 24; i++) begin
      ea = (i == 18 || i == 19 || i == 23) ? 4'd1 : 4'd0;
      do_cmd($sformatf("win_rev%0d", i), 1'b0, i[4:0], 1'b0, 1'b0, ea);
      if (i == 22) check("win_not_yet", 32'({gameover, win}), 32'd0);
    end
    check("win_win", 32'(win), 32'd1);
    check("win_gameover", 32'(gameover), 32'd1);
    check("win_score", global_score, 32'd1);
    check("win_cleared", 32'(cleared), 32'hFFFFFF);
    check("win_state", 32'(state_dbg), 32'(OVER));
    new_game("restart", 1'b1, 25'h0000007, 16'h0);
    check("restart_score", global_score, 32'd1);
    check("restart_cleared", 32'(cleared), 32'd0);
    check("restart_flags", 32'({gameover, win}), 32'd0);

    // LFSR placement, seed 0 twice
    #1 pd0 = pd_cnt;
    new_game("lfsr_a", 1'b0, 25'h0, 16'h0);
    map_a = mines;
    check("lfsr_a_pop", 32'($countones(mines)), 32'd3);
    repeat (4) @(negedge clka);
    #1 check("lfsr_a_pulses", 32'(pd_cnt - pd0), 32'd1);
    pd0 = pd_cnt;
    new_game("lfsr_b", 1'b0, 25'h0, 16'h0);
    check("lfsr_b_pop", 32'($countones(mines)), 32'd3);
    check("lfsr_same_map", 32'(mines), 32'(map_a));
    check("lfsr_b_ready", 32'(cmd_bus.cmd_ready), 32'd1);
    repeat (4) @(negedge clka);
    #1 check("lfsr_b_pulses", 32'(pd_cnt - pd0), 32'd1);

    // Reset during PLACE
    pd0 = pd_cnt;
    @(negedge clka);
    start = 1'b1; load_map = 1'b0; seed = 16'h1234;
    @(negedge clka);
    start = 1'b0;
    check("abort_place_state", 32'(state_dbg), 32'(PLACE));
    @(posedge clka);
    #2 restart_n = 1'b0;
    #1;
    check("abort_place_mines", 32'(mines), 32'd0);
    check("abort_place_idle", 32'(state_dbg), 32'(IDLE));
    check("abort_place_outs", 32'({place_done, gameover, win, cmd_bus.cmd_ready}), 32'd0);
    check("abort_place_score", global_score, 32'd0);
    repeat (4) @(negedge clka);
    #1 check("abort_place_no_done", 32'(pd_cnt - pd0), 32'd0);
    restart_n = 1'b1;

    // Reset during DECODE
    new_game("abort_dec", 1'b1, 25'h0000007, 16'h0);
    #1 r0 = resp_cnt;
    @(negedge clka);
    cmd_bus.cmd_valid = 1'b1; cmd_bus.cmd_op = 1'b0; cmd_bus.cmd_idx = 5'd6;
    @(negedge clka);
    cmd_bus.cmd_valid = 1'b0;
    check("abort_dec_state", 32'(state_dbg), 32'(DECODE));
    restart_n = 1'b0;
    #1;
    check("abort_dec_idle", 32'(state_dbg), 32'(IDLE));
    check("abort_dec_mines", 32'({mines, gameover}), 32'd0);
    check("abort_dec_cleared", 32'(cleared), 32'd0);
    repeat (4) @(negedge clka);
    #1 check("abort_dec_no_resp", 32'(resp_cnt - r0), 32'd0);
    restart_n = 1'b1;

    new_game("op_map", 1'b1, 25'h0000007, 16'h0);
`ifdef MINE_FLAG_EN
    do_cmd("flag3", 1'b1, 5'd3, 1'b0, 1'b0, 4'd0);
    check("flag3_flags", 32'(flags), 32'h8);
    do_cmd("rev_flagged3", 1'b0, 5'd3, 1'b0, 1'b1, 4'd0);
    check("rev_flagged_cleared", 32'(cleared), 32'd0);
    do_cmd("rev7_f", 1'b0, 5'd7, 1'b0, 1'b0, 4'd2);
    do_cmd("flag7_cleared", 1'b1, 5'd7, 1'b0, 1'b0, 4'd0);
    check("flag_cleared_noop", 32'(flags), 32'h8);
    do_cmd("unflag3", 1'b1, 5'd3, 1'b0, 1'b0, 4'd0);
    check("unflag3_flags", 32'(flags), 32'd0);
`else
    do_cmd("op1_rev6", 1'b1, 5'd6, 1'b0, 1'b0, 4'd3);
    check("op1_cleared", 32'(cleared), 32'h40);
    check("op1_flags", 32'(flags), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
